// File: rtl/noc_rx_assembler.sv
// Receive endpoint: rebuilds 32-bit words from MSB-first byte flits, tags them
// with the source node and queues them in a small FIFO for the core.
module noc_rx_assembler #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [16:0]                 f_r,
    output logic                        f_r_rdy,
    output logic [31:0]                 to_c,
    output logic [3:0]                  to_c_src,
    output logic                        to_c_vld,
    input  logic                        c_rdy,
    output logic                        err,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, ASSEMBLE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [31:0]   shift_q, shift_d;
    logic [3:0]    src_q, src_d;
    logic          err_q, err_d;
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [35:0]   mem_q [FIFO_DEPTH];
    logic [35:0]   mem_d [FIFO_DEPTH];

    logic        full, empty, acc, bad, good, push, pop;
    logic [35:0] push_data, head;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level    = wr_q - rd_q;
    assign f_r_rdy  = !full;
    assign acc      = f_r[16] && f_r_rdy;
    assign bad      = acc && (f_r[15:12] != 4'd0);
    assign good     = acc && !bad;
    assign pop      = to_c_vld && c_rdy;
    assign head     = mem_q[rd_q[AW-1:0]];
    assign to_c_vld = !empty;
    assign to_c     = empty ? 32'd0 : head[31:0];
    assign to_c_src = empty ? 4'd0 : head[35:32];
    assign err      = err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        shift_d   = shift_q;
        src_d     = src_q;
        err_d     = bad;
        push      = 1'b0;
        push_data = {src_q, shift_q[31:8], f_r[7:0]};
        case (state_q)
            IDLE: begin
                if (good) begin
                    src_d   = f_r[11:8];
                    shift_d = {f_r[7:0], 24'd0};
                    cnt_d   = 2'd1;
                    timer_d = '0;
                    state_d = ASSEMBLE;
                end
            end
            ASSEMBLE: begin
                if (good && (f_r[11:8] != src_q)) begin
                    // Source switched mid-word: new flit becomes byte 0.
                    err_d   = 1'b1;
                    src_d   = f_r[11:8];
                    shift_d = {f_r[7:0], 24'd0};
                    cnt_d   = 2'd1;
                    timer_d = '0;
                end else if (good) begin
                    timer_d = '0;
                    cnt_d   = cnt_q + 2'd1;
                    case (cnt_q)
                        2'd1:    shift_d[23:16] = f_r[7:0];
                        2'd2:    shift_d[15:8]  = f_r[7:0];
                        default: begin
                            push    = 1'b1;
                            cnt_d   = 2'd0;
                            shift_d = '0;
                            state_d = IDLE;
                        end
                    endcase
                end else if (!bad) begin
                    if (timer_q == TW'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        cnt_d   = 2'd0;
                        shift_d = '0;
                        timer_d = '0;
                        state_d = IDLE;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q[AW-1:0]] = push_data;
            wr_d = wr_q + (AW+1)'(1);
        end
        if (pop) rd_d = rd_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            timer_q <= '0;
            shift_q <= '0;
            src_q   <= '0;
            err_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            shift_q <= shift_d;
            src_q   <= src_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            mem_q   <= mem_d;
        end
    end
endmodule

// File: tb/tb_noc_rx_assembler.sv
// Directed bench for noc_rx_assembler (FIFO_DEPTH=4, TIMEOUT=16).
module tb_noc_rx_assembler;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [16:0] f_r = '0;
    logic        c_rdy = 1'b0;
    logic        f_r_rdy, to_c_vld, err;
    logic [31:0] to_c;
    logic [3:0]  to_c_src;
    logic [2:0]  level;

    int n_chk = 0;
    int n_fail = 0;
    int err_cnt = 0;
    int max_level = 0;
    logic [35:0] popped[$];

    noc_rx_assembler #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .f_r(f_r), .f_r_rdy(f_r_rdy), .to_c(to_c),
        .to_c_src(to_c_src), .to_c_vld(to_c_vld), .c_rdy(c_rdy), .err(err),
        .level(level)
    );

    always #5 clk = ~clk;

    // Mid-cycle observers: error pulses, words handed to the core, FIFO fill.
    always @(negedge clk) begin
        if (err === 1'b1) err_cnt++;
        if (to_c_vld === 1'b1 && c_rdy) popped.push_back({to_c_src, to_c});
        if (int'(level) > max_level) max_level = int'(level);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a flit and hold it until an edge at which f_r_rdy was high.
    task automatic send_flit(input logic [3:0] s, input logic [7:0] b, input logic [3:0] rsv);
        logic ok;
        logic r;
        ok = 1'b0;
        f_r = {1'b1, rsv, s, b};
        for (int i = 0; i < 200; i++) begin
            r = f_r_rdy;
            step();
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        f_r = '0;
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_flit: flit src=%h byte=%h never accepted, want accepted", s, b);
        end
    endtask

    task automatic send_word(input logic [3:0] s, input logic [31:0] w);
        send_flit(s, w[31:24], 4'd0);
        send_flit(s, w[23:16], 4'd0);
        send_flit(s, w[15:8], 4'd0);
        send_flit(s, w[7:0], 4'd0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        n_chk++; if (to_c_vld !== 1'b0) begin n_fail++; $display("FAIL reset vld: got %b want 0", to_c_vld); end
        n_chk++; if (to_c !== 32'd0) begin n_fail++; $display("FAIL reset to_c: got %h want 0", to_c); end
        n_chk++; if (to_c_src !== 4'd0) begin n_fail++; $display("FAIL reset src: got %h want 0", to_c_src); end
        n_chk++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset level: got %0d want 0", level); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset err: got %b want 0", err); end
        n_chk++; if (f_r_rdy !== 1'b1) begin n_fail++; $display("FAIL reset rdy: got %b want 1", f_r_rdy); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int e0;
        e0 = err_cnt;
        c_rdy = 1'b1;
        send_word(4'd3, 32'hDEADBEEF);
        n_chk++; if (to_c_vld !== 1'b1) begin n_fail++; $display("FAIL basic vld: got %b want 1", to_c_vld); end
        n_chk++; if (to_c !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic word: got %h want deadbeef", to_c); end
        n_chk++; if (to_c_src !== 4'd3) begin n_fail++; $display("FAIL basic src: got %h want 3", to_c_src); end
        step();
        n_chk++; if (to_c_vld !== 1'b0) begin n_fail++; $display("FAIL basic vld_drop: got %b want 0", to_c_vld); end
        n_chk++; if (to_c !== 32'd0) begin n_fail++; $display("FAIL basic empty_word: got %h want 0", to_c); end
        n_chk++; if (err_cnt != e0) begin n_fail++; $display("FAIL basic err: got %0d pulses want 0", err_cnt - e0); end
    endtask

    task automatic test_backpressure();
        logic [35:0] exp [5];
        exp[0] = {4'd1, 32'h10111213};
        exp[1] = {4'd2, 32'h20212223};
        exp[2] = {4'd3, 32'h30313233};
        exp[3] = {4'd4, 32'h40414243};
        exp[4] = {4'd5, 32'h50515253};
        c_rdy = 1'b0;
        popped.delete();
        for (int k = 0; k < 4; k++) send_word(exp[k][35:32], exp[k][31:0]);
        n_chk++; if (level !== 3'd4) begin n_fail++; $display("FAIL bp level_full: got %0d want 4", level); end
        n_chk++; if (f_r_rdy !== 1'b0) begin n_fail++; $display("FAIL bp rdy_full: got %b want 0", f_r_rdy); end
        n_chk++; if (to_c !== 32'h10111213) begin n_fail++; $display("FAIL bp head: got %h want 10111213", to_c); end
        f_r = {1'b1, 4'd0, 4'd5, 8'h50};
        step(); step(); step();
        n_chk++; if (level !== 3'd4 || f_r_rdy !== 1'b0) begin
            n_fail++; $display("FAIL bp hold: level=%0d rdy=%b want 4/0", level, f_r_rdy);
        end
        c_rdy = 1'b1;
        send_word(4'd5, 32'h50515253);
        for (int k = 0; k < 6; k++) step();
        n_chk++; if (popped.size() != 5) begin n_fail++; $display("FAIL bp count: got %0d want 5", popped.size()); end
        for (int k = 0; k < 5; k++) begin
            n_chk++;
            if (k >= popped.size() || popped[k] !== exp[k]) begin
                n_fail++;
                $display("FAIL bp order[%0d]: got %h want %h", k, (k < popped.size()) ? popped[k] : 36'h0, exp[k]);
            end
        end
        n_chk++; if (level !== 3'd0 || f_r_rdy !== 1'b1) begin
            n_fail++; $display("FAIL bp drained: level=%0d rdy=%b want 0/1", level, f_r_rdy);
        end
    endtask

    task automatic test_src_switch();
        int e0;
        e0 = err_cnt;
        c_rdy = 1'b1;
        popped.delete();
        send_flit(4'd2, 8'h11, 4'd0);
        send_flit(4'd2, 8'h22, 4'd0);
        send_flit(4'd5, 8'h33, 4'd0);
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL switch err: got %b want 1", err); end
        send_flit(4'd5, 8'h44, 4'd0);
        send_flit(4'd5, 8'h55, 4'd0);
        send_flit(4'd5, 8'h66, 4'd0);
        step(); step();
        n_chk++; if (popped.size() != 1 || popped[0] !== {4'd5, 32'h33445566}) begin
            n_fail++; $display("FAIL switch word: n=%0d got %h want 533445566", popped.size(), popped[0]);
        end
        n_chk++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL switch pulses: got %0d want 1", err_cnt - e0); end
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_cnt;
        c_rdy = 1'b1;
        popped.delete();
        send_flit(4'd1, 8'hAA, 4'd0);
        send_flit(4'd1, 8'hBB, 4'd0);
        for (int k = 0; k < 15; k++) step();
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL timeout early: got %b want 0", err); end
        step();
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout pulse: got %b want 1", err); end
        step();
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL timeout width: got %b want 0", err); end
        send_word(4'd1, 32'h01020304);
        step(); step();
        n_chk++; if (popped.size() != 1 || popped[0] !== {4'd1, 32'h01020304}) begin
            n_fail++; $display("FAIL timeout word: n=%0d got %h want 101020304", popped.size(), popped[0]);
        end
        n_chk++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL timeout pulses: got %0d want 1", err_cnt - e0); end
    endtask

    task automatic test_timeout_edge();
        int e0;
        e0 = err_cnt;
        c_rdy = 1'b1;
        popped.delete();
        send_flit(4'd6, 8'h61, 4'd0);
        send_flit(4'd6, 8'h62, 4'd0);
        for (int k = 0; k < 15; k++) step();
        send_flit(4'd6, 8'h63, 4'd0);
        send_flit(4'd6, 8'h64, 4'd0);
        step(); step();
        n_chk++; if (popped.size() != 1 || popped[0] !== {4'd6, 32'h61626364}) begin
            n_fail++; $display("FAIL tedge word: n=%0d got %h want 661626364", popped.size(), popped[0]);
        end
        n_chk++; if (err_cnt != e0) begin n_fail++; $display("FAIL tedge err: got %0d pulses want 0", err_cnt - e0); end
    endtask

    task automatic test_reserved();
        int e0;
        e0 = err_cnt;
        c_rdy = 1'b1;
        popped.delete();
        send_flit(4'd7, 8'hAA, 4'd0);
        send_flit(4'd7, 8'hFF, 4'hA);
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL rsv err: got %b want 1", err); end
        send_flit(4'd7, 8'hBB, 4'd0);
        send_flit(4'd7, 8'hCC, 4'd0);
        send_flit(4'd7, 8'hDD, 4'd0);
        step(); step();
        n_chk++; if (popped.size() != 1 || popped[0] !== {4'd7, 32'hAABBCCDD}) begin
            n_fail++; $display("FAIL rsv word: n=%0d got %h want 7aabbccdd", popped.size(), popped[0]);
        end
        n_chk++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL rsv pulses: got %0d want 1", err_cnt - e0); end
    endtask

    task automatic test_reset_mid();
        c_rdy = 1'b0;
        popped.delete();
        send_word(4'd6, 32'h11223344);
        send_word(4'd6, 32'h55667788);
        send_flit(4'd8, 8'h81, 4'd0);
        send_flit(4'd8, 8'h82, 4'd0);
        n_chk++; if (level !== 3'd2) begin n_fail++; $display("FAIL rmid pre_level: got %0d want 2", level); end
        #2 rst = 1'b0;
        #1;
        n_chk++; if (to_c_vld !== 1'b0 || to_c !== 32'd0) begin
            n_fail++; $display("FAIL rmid vld: vld=%b to_c=%h want 0/0", to_c_vld, to_c);
        end
        n_chk++; if (level !== 3'd0) begin n_fail++; $display("FAIL rmid level: got %0d want 0", level); end
        n_chk++; if (f_r_rdy !== 1'b1) begin n_fail++; $display("FAIL rmid rdy: got %b want 1", f_r_rdy); end
        step();
        rst = 1'b1;
        step();
        c_rdy = 1'b1;
        send_word(4'd8, 32'h91929394);
        step(); step();
        n_chk++; if (popped.size() != 1 || popped[0] !== {4'd8, 32'h91929394}) begin
            n_fail++; $display("FAIL rmid word: n=%0d got %h want 891929394", popped.size(), popped[0]);
        end
    endtask

    task automatic test_full_pop();
        logic [35:0] exp [5];
        exp[0] = {4'd1, 32'hA0A1A2A3};
        exp[1] = {4'd2, 32'hB0B1B2B3};
        exp[2] = {4'd3, 32'hC0C1C2C3};
        exp[3] = {4'd4, 32'hD0D1D2D3};
        exp[4] = {4'd9, 32'hE0E1E2E3};
        c_rdy = 1'b0;
        popped.delete();
        for (int k = 0; k < 4; k++) send_word(exp[k][35:32], exp[k][31:0]);
        f_r = {1'b1, 4'd0, 4'd9, 8'hE0};
        step(); step();
        c_rdy = 1'b1;
        step();
        c_rdy = 1'b0;
        n_chk++; if (level !== 3'd3 || f_r_rdy !== 1'b1) begin
            n_fail++; $display("FAIL fullpop after_pop: level=%0d rdy=%b want 3/1", level, f_r_rdy);
        end
        step();
        send_flit(4'd9, 8'hE1, 4'd0);
        send_flit(4'd9, 8'hE2, 4'd0);
        send_flit(4'd9, 8'hE3, 4'd0);
        n_chk++; if (level !== 3'd4) begin n_fail++; $display("FAIL fullpop refill: got %0d want 4", level); end
        c_rdy = 1'b1;
        for (int k = 0; k < 7; k++) step();
        n_chk++; if (popped.size() != 5) begin n_fail++; $display("FAIL fullpop count: got %0d want 5", popped.size()); end
        for (int k = 0; k < 5; k++) begin
            n_chk++;
            if (k >= popped.size() || popped[k] !== exp[k]) begin
                n_fail++;
                $display("FAIL fullpop order[%0d]: got %h want %h", k, (k < popped.size()) ? popped[k] : 36'h0, exp[k]);
            end
        end
        n_chk++; if (max_level > 4) begin n_fail++; $display("FAIL fullpop max_level: got %0d want <=4", max_level); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_src_switch();
        test_timeout();
        test_timeout_edge();
        test_reserved();
        test_reset_mid();
        test_full_pop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
